pipe_stall_ctrl: RTL and testbench

- Consumes the ID-stage stall request from the hazard detector, the EX-stage branch redirect, and the memory-busy signal.
- Drives the enables, flushes and bubble-inserts of the in-order pipeline registers (PC, IF/ID, ID/EX).
- Sequences multi-cycle stalls and multi-cycle flushes with an internal counter.
- Optionally keeps stall and flush performance counters.

---
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer for PC, IF/ID and ID/EX registers.
// Optional performance counters are enabled with the PIPE_STALL_PERF_EN macro.
module pipe_stall_ctrl #(
  parameter int CNT_W     = 4,
  parameter int FLUSH_LEN = 2,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_i,
  input  logic [CNT_W-1:0]  stall_len_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              idex_en_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] FLUSH_REM = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] len_eff;
  logic             flush_act;
  logic             stall_act;
  logic             run_act;

  // Cycle classification in priority order: freeze, flush, stall, run.
  always_comb begin
    len_eff   = (stall_len_i == '0) ? ONE : stall_len_i;
    flush_act = !mem_busy_i && (flush_i || state == FLUSH);
    stall_act = !mem_busy_i && !flush_act && (hazard_i || state == STALL);
    run_act   = !mem_busy_i && !flush_act && !stall_act;
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    pc_en_o       = rst_n & (flush_act | run_act);
    ifid_en_o     = rst_n & (flush_act | run_act);
    ifid_flush_o  = rst_n & flush_act;
    idex_bubble_o = rst_n & (flush_act | stall_act);
    idex_en_o     = rst_n & !mem_busy_i;
    busy_o        = rst_n & (state != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      remain <= '0;
    end else if (!mem_busy_i) begin
      if (flush_i) begin
        if (FLUSH_LEN > 1) begin
          state  <= FLUSH;
          remain <= FLUSH_REM;
        end else begin
          state  <= RUN;
          remain <= '0;
        end
      end else begin
        case (state)
          RUN: begin
            if (hazard_i && len_eff > ONE) begin
              state  <= STALL;
              remain <= len_eff - ONE;
            end
          end
          STALL, FLUSH: begin
            if (remain <= ONE) begin
              state  <= RUN;
              remain <= '0;
            end else begin
              remain <= remain - ONE;
            end
          end
          default: begin
            state  <= RUN;
            remain <= '0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (!mem_busy_i && flush_i)
        flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random traffic
// against a cycle-count reference model; a 4-bit-counter instance covers saturation.
module tb_pipe_stall_ctrl;

  localparam int FLUSH_LEN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard_i = 1'b0;
  logic [3:0]  stall_len_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_busy_i = 1'b0;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, busy;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, ifid_flush4, idex_bubble4, idex_en4, busy4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(4), .FLUSH_LEN(FLUSH_LEN), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_i(hazard_i), .stall_len_i(stall_len_i),
    .flush_i(flush_i), .mem_busy_i(mem_busy_i),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .idex_en_o(idex_en), .busy_o(busy),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4), .FLUSH_LEN(FLUSH_LEN), .PERF_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hazard_i(hazard_i), .stall_len_i(stall_len_i),
    .flush_i(flush_i), .mem_busy_i(mem_busy_i),
    .pc_en_o(pc_en4), .ifid_en_o(ifid_en4), .ifid_flush_o(ifid_flush4),
    .idex_bubble_o(idex_bubble4), .idex_en_o(idex_en4), .busy_o(busy4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
  );

  typedef struct packed {
    logic [5:0]  ctl;   // {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, busy}
    logic [31:0] sc;
    logic [31:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining stall / flush cycles and event totals.
  int bub_left = 0;
  int fl_left  = 0;
  int scnt     = 0;
  int fcnt     = 0;

  function automatic logic [31:0] perf(input int v);
`ifdef PIPE_STALL_PERF_EN
    return 32'(v);
`else
    return 32'(0 * v);
`endif
  endfunction

  function automatic logic [3:0] perf4(input int v);
`ifdef PIPE_STALL_PERF_EN
    return (v > 15) ? 4'd15 : 4'(v);
`else
    return 4'(0 * v);
`endif
  endfunction

  task automatic step(input logic r, input logic hz, input logic [3:0] ln,
                      input logic fl, input logic mb);
    exp_t e;
    logic bsy;
    int   len;
    @(posedge clk);
    #1;
    rst_n = r; hazard_i = hz; stall_len_i = ln; flush_i = fl; mem_busy_i = mb;
    if (!r) begin
      bub_left = 0; fl_left = 0; scnt = 0; fcnt = 0;
    end
    e.sc  = perf(scnt);
    e.fc  = perf(fcnt);
    e.sc4 = perf4(scnt);
    e.fc4 = perf4(fcnt);
    bsy   = (bub_left > 0) || (fl_left > 0);
    len   = (ln == 4'd0) ? 1 : int'(ln);
    if (!r) begin
      e.ctl = 6'b000000;
    end else if (mb) begin
      e.ctl = {5'b00000, bsy};
    end else if (fl || fl_left > 0) begin
      e.ctl = {5'b11111, bsy};
      if (fl) begin
        fl_left = FLUSH_LEN - 1; bub_left = 0; fcnt++;
      end else begin
        fl_left--;
      end
    end else if (hz || bub_left > 0) begin
      e.ctl = {5'b00011, bsy};
      scnt++;
      if (bub_left > 0) bub_left--;
      else bub_left = len - 1;
    end else begin
      e.ctl = 6'b110010;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle and sampled mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, busy} != e.ctl) begin
        errors++;
        $display("FAIL ctl t=%0t got=%b want=%b", $time,
                 {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, busy}, e.ctl);
      end
      checks++;
      if (stall_cnt != e.sc || flush_cnt != e.fc) begin
        errors++;
        $display("FAIL cnt32 t=%0t got=%0d/%0d want=%0d/%0d", $time,
                 stall_cnt, flush_cnt, e.sc, e.fc);
      end
      checks++;
      if ({pc_en4, ifid_en4, ifid_flush4, idex_bubble4, idex_en4, busy4} != e.ctl ||
          stall_cnt4 != e.sc4 || flush_cnt4 != e.fc4) begin
        errors++;
        $display("FAIL dut4 t=%0t got=%b %0d/%0d want=%b %0d/%0d", $time,
                 {pc_en4, ifid_en4, ifid_flush4, idex_bubble4, idex_en4, busy4},
                 stall_cnt4, flush_cnt4, e.ctl, e.sc4, e.fc4);
      end
    end
  end

  initial begin
    // Reset held 3 cycles, then idle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(5);
    // Three-cycle stall.
    step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(4);
    // Zero length behaves as one bubble.
    step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    idle(2);
    // Flush in cycle 2 of a 4-cycle stall, with a hazard presented alongside.
    step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    idle(4);
    // Freeze in the middle of a 3-cycle stall.
    step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'd7, 1'b0, 1'b1);
    idle(4);
    // Flush restarted inside FLUSH, then reset pulse mid-FLUSH.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(3);
    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 200) != 0, ($urandom % 4) == 0, 4'($urandom % 16),
           ($urandom % 12) == 0, ($urandom % 8) == 0);
    end
    idle(3);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
